// File: rtl/spi_reg_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_responder_if
// Brief   : SPI pins, local register read port and write-notify bundle for
//           spi_reg_responder.
// Revision: 1.0 - initial release
// ============================================================================
interface spi_reg_responder_if;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_ss_n;
    logic       spi_miso;
    logic [7:0] status_in;
    logic [4:0] reg_rd_addr;
    logic [7:0] reg_rd_data;
    logic       wr_strobe;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;

    modport master (
        output spi_sclk, spi_mosi, spi_ss_n, status_in, reg_rd_addr,
        input  spi_miso, reg_rd_data, wr_strobe, wr_addr, wr_data, frame_err
    );

    modport slave (
        input  spi_sclk, spi_mosi, spi_ss_n, status_in, reg_rd_addr,
        output spi_miso, reg_rd_data, wr_strobe, wr_addr, wr_data, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_responder
// Brief   : SPI mode-0 slave exposing a 32 x 8-bit register file with
//           MAX3421E-style command framing. Optional macro
//           SPI_REG_AUTOINC_EN auto-increments the address per data byte.
// Revision: 1.0 - initial release
// ============================================================================
module spi_reg_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NREGS       = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    spi_reg_responder_if.slave  bus
);

    localparam int c_ADDR_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WR   = 2'd2,
        S_RD   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;
    logic                   r_armed;

    state_t                 r_state;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_rx;
    logic [7:0]             r_tx;
    logic [c_ADDR_W-1:0]    r_addr;
    logic [7:0]             r_regs [NREGS];

    logic                   r_miso;
    logic                   r_wr_strobe;
    logic [c_ADDR_W-1:0]    r_wr_addr;
    logic [7:0]             r_wr_data;
    logic                   r_frame_err;

    logic                   w_sclk;
    logic                   w_mosi;
    logic                   w_ss_n;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_ss_fall;
    logic                   w_ss_rise;
    logic [7:0]             w_byte;
    logic                   w_last_bit;
    logic [c_ADDR_W-1:0]    w_next_addr;
    logic [7:0]             w_cmd_rd_data;
    logic [7:0]             w_next_rd_data;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_n      = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk &  r_sclk_d;
    // A frame may only start once ss_n has been seen high since reset.
    assign w_ss_fall   =  r_ss_d & ~w_ss_n & r_armed;
    assign w_ss_rise   = ~r_ss_d &  w_ss_n;

    assign w_byte     = {r_rx, w_mosi};
    assign w_last_bit = (r_bit_cnt == 3'd7);

`ifdef SPI_REG_AUTOINC_EN
    assign w_next_addr = r_addr + 5'd1;
`else
    assign w_next_addr = r_addr;
`endif

    assign w_cmd_rd_data  = r_regs[w_byte[7:3]];
    assign w_next_rd_data = r_regs[w_next_addr];

    assign bus.spi_miso    = r_miso;
    assign bus.wr_strobe   = r_wr_strobe;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign bus.frame_err   = r_frame_err;
    assign bus.reg_rd_data = r_regs[bus.reg_rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // ss_n sync resets low so a select held low across reset never
            // looks like a fresh falling edge.
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b0;
            r_armed     <= 1'b0;
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_addr      <= '0;
            r_miso      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.spi_ss_n};
            r_sclk_d    <= w_sclk;
            r_ss_d      <= w_ss_n;
            r_armed     <= r_armed | w_ss_n;
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_ss_fall) begin
                        r_tx      <= bus.status_in;
                        r_miso    <= bus.status_in[7];
                        r_bit_cnt <= 3'd0;
                        r_state   <= S_CMD;
                    end
                end
                default: begin
                    if (w_ss_rise) begin
                        r_state   <= S_IDLE;
                        r_miso    <= 1'b0;
                        r_bit_cnt <= 3'd0;
                        if (r_bit_cnt != 3'd0) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sclk_rise) begin
                        r_rx      <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            case (r_state)
                                S_CMD: begin
                                    r_addr <= w_byte[7:3];
                                    if (w_byte[1]) begin
                                        r_state <= S_WR;
                                        r_tx    <= '0;
                                        r_miso  <= 1'b0;
                                    end else begin
                                        r_state <= S_RD;
                                        r_tx    <= w_cmd_rd_data;
                                        r_miso  <= w_cmd_rd_data[7];
                                    end
                                end
                                S_WR: begin
                                    r_regs[r_addr] <= w_byte;
                                    r_wr_strobe    <= 1'b1;
                                    r_wr_addr      <= r_addr;
                                    r_wr_data      <= w_byte;
                                    r_addr         <= w_next_addr;
                                end
                                default: begin
                                    r_tx   <= w_next_rd_data;
                                    r_miso <= w_next_rd_data[7];
                                    r_addr <= w_next_addr;
                                end
                            endcase
                        end
                    end else if (w_sclk_fall && (r_bit_cnt != 3'd0)) begin
                        // The fall after the 8th rise keeps the freshly loaded MSB.
                        r_tx   <= {r_tx[6:0], 1'b0};
                        r_miso <= r_tx[6];
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_reg_responder
// Brief   : Self-checking bench for spi_reg_responder against a byte-level
//           register-file model (honours SPI_REG_AUTOINC_EN).
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_reg_responder;

    localparam int c_HALF = 6;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] model [32];
    wr_t        obs_wr[$];
    wr_t        exp_wr[$];
    int         obs_ferr = 0;

    always #5 clk = ~clk;

    spi_reg_responder_if bus ();

    spi_reg_responder #(
        .SYNC_STAGES (2),
        .NREGS       (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_strobe) obs_wr.push_back(wr_t'({bus.wr_addr, bus.wr_data}));
            if (bus.frame_err) obs_ferr++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = tx[7-i];
            wait_clks(c_HALF);
            rx = {rx[6:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            wait_clks(c_HALF);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic clear_obs();
        obs_wr.delete();
        exp_wr.delete();
        obs_ferr = 0;
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < 32; i++) begin
            bus.reg_rd_addr = 5'(i);
            #1;
            checks++;
            if (bus.reg_rd_data !== model[i]) begin
                errors++;
                $display("FAIL %s reg[%0d]: got %h expected %h", name, i, bus.reg_rd_data, model[i]);
            end
        end
    endtask

    task automatic check_writes(input string name, input int exp_ferr);
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d expected %0d", name, obs_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[k]) begin
                checks++;
                if (obs_wr[k] !== exp_wr[k]) begin
                    errors++;
                    $display("FAIL %s write%0d: got addr %0d data %h expected addr %0d data %h",
                             name, k, obs_wr[k].a, obs_wr[k].d, exp_wr[k].a, exp_wr[k].d);
                end
            end
        end
        checks++;
        if (obs_ferr != exp_ferr) begin
            errors++;
            $display("FAIL %s frame_err_count: got %0d expected %0d", name, obs_ferr, exp_ferr);
        end
    endtask

    // Whole-frame model: status byte first, then per data byte either a write
    // (master sees 0x00) or a read of the current register.
    task automatic run_frame(input logic [7:0] status, input logic [7:0] cmd,
                             input byte_q_t data, input string name);
        logic [7:0] rx;
        logic [7:0] exp_rx;
        logic [4:0] addr;
        clear_obs();
        bus.status_in = status;
        bus.spi_ss_n  = 1'b0;
        wait_clks(c_HALF + 2);
        spi_bits(cmd, 8, rx);
        checks++;
        if (rx !== status) begin
            errors++;
            $display("FAIL %s status_byte: got %h expected %h", name, rx, status);
        end
        addr = cmd[7:3];
        foreach (data[k]) begin
            spi_bits(data[k], 8, rx);
            if (cmd[1]) begin
                exp_rx = 8'h00;
                model[addr] = data[k];
                exp_wr.push_back(wr_t'({addr, data[k]}));
            end else begin
                exp_rx = model[addr];
            end
`ifdef SPI_REG_AUTOINC_EN
            addr = addr + 5'd1;
`endif
            checks++;
            if (rx !== exp_rx) begin
                errors++;
                $display("FAIL %s data_byte%0d: got %h expected %h", name, k, rx, exp_rx);
            end
        end
        wait_clks(c_HALF);
        bus.spi_ss_n = 1'b1;
        wait_clks(10);
        check_writes(name, 0);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({bus.spi_miso, bus.wr_strobe, bus.wr_addr, bus.wr_data, bus.frame_err} !== 16'h0) begin
            errors++;
            $display("FAIL %s outputs: got miso=%b strb=%b addr=%0d data=%h ferr=%b expected all zero",
                     name, bus.spi_miso, bus.wr_strobe, bus.wr_addr, bus.wr_data, bus.frame_err);
        end
    endtask

    task automatic test_reset();
        bus.spi_sclk    = 1'b0;
        bus.spi_mosi    = 1'b0;
        bus.spi_ss_n    = 1'b1;
        bus.status_in   = 8'h00;
        bus.reg_rd_addr = 5'd0;
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(5);
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        check_idle_outputs("reset");
        check_regs("reset");
    endtask

    task automatic test_directed();
        run_frame(8'hA5, 8'h52, '{8'h3C}, "write_r10");
        run_frame(8'hA5, 8'h50, '{8'($urandom)}, "read_r10");
        checks++;
        if (model[10] !== 8'h3C) begin
            errors++;
            $display("FAIL model_r10: got %h expected %h", model[10], 8'h3C);
        end
        run_frame(8'h5A, 8'hFA, '{8'h11, 8'h22}, "write_r31_x2");
        check_regs("directed");
    endtask

    task automatic test_frame_err();
        logic [7:0] rx;
        run_frame(8'h00, 8'h2A, '{8'h77}, "write_r5");
        clear_obs();
        bus.status_in = 8'($urandom);
        bus.spi_ss_n  = 1'b0;
        wait_clks(c_HALF + 2);
        spi_bits(8'h2A, 8, rx);
        spi_bits(8'h88, 4, rx);
        wait_clks(c_HALF);
        bus.spi_ss_n = 1'b1;
        wait_clks(10);
        check_writes("partial_byte", 1);
        check_regs("partial_byte");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rx;
        clear_obs();
        bus.status_in = 8'hC3;
        bus.spi_ss_n  = 1'b0;
        wait_clks(c_HALF + 2);
        spi_bits(8'h1A, 8, rx);
        rst = 1'b1;
        wait_clks(2);
        check_idle_outputs("in_reset");
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        spi_bits(8'h99, 8, rx);
        wait_clks(2);
        check_idle_outputs("after_reset");
        wait_clks(c_HALF);
        bus.spi_ss_n = 1'b1;
        wait_clks(10);
        check_writes("reset_midframe", 0);
        check_regs("reset_midframe");
        run_frame(8'h3C, 8'h1A, '{8'h4D}, "post_reset_write");
        run_frame(8'h3C, 8'h18, '{8'h00}, "post_reset_read");
    endtask

    task automatic test_random();
        byte_q_t data;
        for (int f = 0; f < 20; f++) begin
            data.delete();
            for (int k = 0; k < int'($urandom_range(3, 1)); k++) data.push_back(8'($urandom));
            run_frame(8'($urandom), 8'($urandom), data, $sformatf("rand%0d", f));
        end
        check_regs("random");
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_directed();
        test_frame_err();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI-mode-0 slave that sits at the far end of the SoC's spi0 master (MOSI/SCLK/SS_n in, MISO out).
- Exposes a 32 x 8-bit register file using the MAX3421E-style framing.
- Used as an on-chip stand-in for the USB controller in loopback/simulation builds, and as a generic register peripheral for fabric logic.
- Fabric logic reads registers through a local port and is told of every SPI write.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sclk/mosi/ss_n (legal range 2-3).
- NREGS, 32, register count; register address width is 5 bits, fixed.

Ports:
- Clk  input  1  system clock; every flop is on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- spi_sclk  input  1  SPI clock from master, CPOL=0.
- spi_mosi  input  1  master-out data.
- spi_ss_n  input  1  active-low frame select.
- spi_miso  output  1  slave-out data.
- status_in  input  8  byte returned on MISO during the command byte.
- reg_rd_addr  input  5  local read address.
- reg_rd_data  output  8  combinational read of regfile[reg_rd_addr].
- wr_strobe  output  1  one-cycle pulse per committed SPI write.
- wr_addr  output  5  register written; valid while wr_strobe=1.
- wr_data  output  8  data written; valid while wr_strobe=1.
- frame_err  output  1  one-cycle pulse when SS_n rises mid-byte.

Behaviour:
- Reset:
  - All registers = 0x00.
  - spi_miso=0, wr_strobe=0, wr_addr=0, wr_data=0, frame_err=0.
  - FSM in IDLE; bit counter = 0.
- Input conditioning:
  - sclk, mosi and ss_n pass through SYNC_STAGES flops.
  - sclk edges are detected on the synchronized signal.
  - Requirement: SCLK high and low times must each be >= SYNC_STAGES+1 Clk periods.
- Timing:
  - MOSI is sampled on the detected rising edge of SCLK.
  - spi_miso advances on the detected falling edge.
  - Bytes are MSB first.
- FSM states: IDLE, CMD, WR, RD.
- IDLE:
  - On ss_n falling: load status_in into the TX shifter.
  - Drive spi_miso = status_in[7] on the next Clk.
  - Clear the bit counter; go to CMD.
- CMD, after the 8th rising edge:
  - addr = cmd[7:3].
  - cmd[1]=1 -> WR.
  - cmd[1]=0 -> RD: load regfile[addr] into the TX shifter and drive its MSB immediately.
  - cmd[2] and cmd[0] are ignored.
- WR, after each 8th rising edge:
  - regfile[addr] <= byte.
  - wr_strobe=1 with wr_addr/wr_data for exactly one cycle, the cycle after the edge is detected.
  - spi_miso returns 0x00 bits during WR.
- RD, after each 8th rising edge:
  - Reload the TX shifter with regfile[addr]; no strobe.
- Addressing: addr is held for the whole frame. Without the optional feature, repeated data bytes access the same register (FIFO-style).
- ss_n rising:
  - Any state returns to IDLE at once.
  - If the bit counter != 0: the partial byte is discarded, no write occurs, and frame_err pulses for 1 cycle.
  - A rise with counter=0 is a clean end with no error.
- spi_miso = 0 whenever in IDLE.
- Local read port:
  - reg_rd_data is combinational from the array.
  - A write becomes visible on reg_rd_data in the cycle wr_strobe is high (the array updates on the strobe-generating edge).
- Reset asserted mid-frame: immediate return to the reset state. The remainder of that frame is ignored until ss_n is seen high and then falls again.

Optional Feature:
- Macro: SPI_REG_AUTOINC_EN.
- When defined: addr increments after every completed data byte in WR and RD, wrapping 31 -> 0. In RD, the next byte loads regfile[addr+1].
- When undefined: addr is fixed for the frame as described above.

Test Plan:
- Reset, then read regs 0..31 via the local port -> all 0x00; spi_miso=0; no strobe.
- status_in=0xA5; frame with cmd 0x52 (reg 10, write), data 0x3C -> master receives 0xA5 then 0x00; one wr_strobe with wr_addr=10, wr_data=0x3C; regfile[10]=0x3C.
- Continue with cmd 0x50 (reg 10, read) plus one dummy byte -> master receives 0x3C in the second byte; no wr_strobe.
- Write frame to reg 31 with 2 data bytes 0x11, 0x22:
  - Without the macro: two strobes, both addr 31; final regfile[31]=0x22.
  - With SPI_REG_AUTOINC_EN: strobes at addr 31 then 0; regfile[31]=0x11, regfile[0]=0x22.
- Write frame to reg 5 with SS_n raised after 4 data bits -> frame_err pulses once; no strobe; regfile[5] unchanged.
- Assert Reset after the command byte of a write frame -> no strobe; outputs return to reset values. The next complete frame works normally.
